// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory for the MIPS core: one request at a time,
// a fixed number of wait states, then a registered single-cycle response.
module mips_dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam bit USE_LIVE = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [3:0]        lat_be;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic              op_we;
    logic [31:0]       op_addr;
    logic [3:0]        op_be;
    logic [DATA_W-1:0] op_wdata;
    logic [AW-1:0]     op_idx;
    logic              op_err;

    // With no wait states the memory acts on the accept edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        accept   = (state == IDLE) && req_valid && req_ready;
        op_we    = USE_LIVE ? req_we    : lat_we;
        op_addr  = USE_LIVE ? req_addr  : lat_addr;
        op_be    = USE_LIVE ? req_be    : lat_be;
        op_wdata = USE_LIVE ? req_wdata : lat_wdata;
        op_idx   = op_addr[AW+1:2];
        op_err   = (op_addr[1:0] != 2'b00) ||
                   ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
        if (USE_LIVE) begin
            commit = accept && reset;
        end else begin
            commit = (state == WAIT) && (cnt == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_be    <= req_be;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (USE_LIVE) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (commit) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? '0 : mem[op_idx];
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a 2-wait-state and a 0-wait-state instance
// share the request fields; each has its own req_valid and response ports.
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid2 = 1'b0;
    logic        valid0 = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;

    logic        ready2, rspv2, err2;
    logic [31:0] rdata2;
    logic        ready0, rspv0, err0;
    logic [31:0] rdata0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .req_ready(ready2), .rsp_valid(rspv2), .rsp_rdata(rdata2),
        .rsp_err(err2)
    );

    mips_dmem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(valid0), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .req_ready(ready0), .rsp_valid(rspv0), .rsp_rdata(rdata0),
        .rsp_err(err0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_after;
    int          obs_lat;
    int          obs_rdy;

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready0 : ready2;
    endfunction

    function automatic logic rspv(input int sel);
        return (sel == 0) ? rspv0 : rspv2;
    endfunction

    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? rdata0 : rdata2;
    endfunction

    function automatic logic er(input int sel);
        return (sel == 0) ? err0 : err2;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid0 = v;
        else valid2 = v;
    endtask

    task automatic push(input logic [31:0] d, input logic er_, input int lat);
        exp_t x;
        x.rdata = d;
        x.err = er_;
        x.lat = lat;
        sb.push_back(x);
    endtask

    // Issue one request, optionally keep req_valid high with a junk store
    // while busy; capture latency, response and the cycle after it.
    task automatic send(input int sel, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input bit hold);
        @(negedge clk);
        req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        set_valid(sel, 1'b1);
        for (int n = 0; n < 20 && rdy(sel) !== 1'b1; n++) @(negedge clk);
        @(posedge clk);
        #1;
        if (hold) begin
            req_we = 1'b1; req_addr = 32'h0;
            req_be = 4'hF; req_wdata = 32'hBADBAD00;
        end else begin
            set_valid(sel, 1'b0);
        end
        obs_lat = -1; obs_rdy = 0; obs_rdata = 'x; obs_err = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy(sel) !== 1'b0) obs_rdy++;
            if (rspv(sel) === 1'b1) begin
                obs_lat = k; obs_rdata = rd(sel); obs_err = er(sel);
                break;
            end
        end
        set_valid(sel, 1'b0);
        @(negedge clk);
        obs_after = rspv(sel);
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks += 2;
            if ({ready2, rspv2, rdata2, err2} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_w2 got rdy=%b v=%b d=%h e=%b exp 1 0 0 0", ready2, rspv2, rdata2, err2);
            end
            if ({ready0, rspv0, rdata0, err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_w0 got rdy=%b v=%b d=%h e=%b exp 1 0 0 0", ready0, rspv0, rdata0, err0);
            end
        end
        #2 reset = 1'b1;
        @(negedge clk);
        checks += 2;
        if ({ready2, rspv2, rdata2, err2} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_w2 got rdy=%b v=%b d=%h e=%b exp 1 0 0 0", ready2, rspv2, rdata2, err2);
        end
        if ({ready0, rspv0, rdata0, err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_w0 got rdy=%b v=%b d=%h e=%b exp 1 0 0 0", ready0, rspv0, rdata0, err0);
        end
    endtask

    task automatic test_store_load;
        push(32'h0, 1'b0, 2);
        send(2, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        e = sb.pop_front(); checks += 2;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL st_rsp got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL st_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
        push(32'hDEADBEEF, 1'b0, 2);
        send(2, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks += 2;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL ld_rsp got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL ld_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
    endtask

    task automatic test_byte_enable;
        push(32'h0, 1'b0, 2);
        send(2, 1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL be_st got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'hDE22BE44, 1'b0, 2);
        send(2, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL be_ld got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_errors;
        push(32'h0, 1'b0, 2);
        send(2, 1'b1, 32'h0, 4'hF, 32'h01234567, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL err_init got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'h0, 1'b1, 2);
        send(2, 1'b0, 32'h12, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks += 2;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL err_misalign got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL err_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
        push(32'h0, 1'b1, 2);
        send(2, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL err_range got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'h01234567, 1'b0, 2);
        send(2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL err_keep got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_handshake;
        int extra;
        push(32'h0, 1'b0, 2);
        send(2, 1'b1, 32'h8, 4'hF, 32'h55AA55AA, 1'b1);
        e = sb.pop_front(); checks += 3;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL hs_rsp got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL hs_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
        if (obs_rdy != 0) begin errors++; $display("FAIL hs_ready got %0d busy cycles with ready exp 0", obs_rdy); end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rspv2 !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL hs_extra got %0d extra responses exp 0", extra); end
        push(32'h01234567, 1'b0, 2);
        send(2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL hs_junk got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'h55AA55AA, 1'b0, 2);
        send(2, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL hs_ld got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_reset_mid;
        int seen;
        push(32'h0, 1'b0, 2);
        send(2, 1'b1, 32'h20, 4'hF, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL rm_init got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        seen = 0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
        valid2 = 1'b1;
        for (int n = 0; n < 20 && ready2 !== 1'b1; n++) @(negedge clk);
        @(posedge clk);
        #1 valid2 = 1'b0;
        @(negedge clk);
        if (rspv2 !== 1'b0) seen++;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({ready2, rspv2, rdata2, err2} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL rm_in_reset got rdy=%b v=%b d=%h e=%b exp 1 0 0 0", ready2, rspv2, rdata2, err2);
            end
        end
        #2 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rspv2 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rm_aborted got %0d responses exp 0", seen); end
        push(32'h0, 1'b0, 2);
        send(2, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL rm_ld got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
    endtask

    task automatic test_w0;
        push(32'h0, 1'b0, 0);
        send(0, 1'b1, 32'h20, 4'hF, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL w0_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
        push(32'h0, 1'b0, 0);
        send(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL w0_st got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'h0, 1'b0, 0);
        send(0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL w0_be0 got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        push(32'hDEADBEEF, 1'b0, 0);
        send(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        e = sb.pop_front(); checks += 2;
        if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin errors++; $display("FAIL w0_ld got %b/%h exp %b/%h", obs_err, obs_rdata, e.err, e.rdata); end
        if (obs_lat != e.lat || obs_after !== 1'b0) begin errors++; $display("FAIL w0_ld_lat got %0d tail %b exp %0d tail 0", obs_lat, obs_after, e.lat); end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        int gaps;
        @(negedge clk);
        req_we = 1'b0; req_be = 4'h0; req_addr = 32'h10; valid0 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (rspv0 === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got response %h exp none", rdata0);
                end else begin
                    e = sb.pop_front();
                    if ({err0, rdata0} !== {e.err, e.rdata}) begin errors++; $display("FAIL b2b_rsp got %b/%h exp %b/%h", err0, rdata0, e.err, e.rdata); end
                end
                req_addr = (req_addr == 32'h10) ? 32'h20 : 32'h10;
            end
            if (ready0 === 1'b1) begin
                acc.push_back(c);
                push((req_addr == 32'h10) ? 32'hDEADBEEF : 32'h0, 1'b0, 0);
            end
        end
        valid0 = 1'b0;
        gaps = 0;
        for (int i = 1; i < acc.size(); i++) begin
            if (acc[i] - acc[i-1] != 2) gaps++;
        end
        checks += 3;
        if (acc.size() != 6) begin errors++; $display("FAIL b2b_count got %0d accepts exp 6", acc.size()); end
        if (gaps != 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", gaps); end
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d unanswered exp 0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_enable;
        test_errors;
        test_handshake;
        test_reset_mid;
        test_w0;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
